// File: rtl/bru_redirect_ctrl.sv
// Branch-resolution controller: checks each resolved control transfer against its
// fetch-time prediction, redirects fetch on a mispredict and emits predictor updates.

package rei_pkg;
  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            tkn;
    logic [XLEN-1:0] tgt;
  } upd_t;
endpackage

module bru_redirect_ctrl
  import rei_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ex_valid_i,
  input  logic             ex_is_ctrl_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic             bru_tkn_i,
  input  logic [XLEN-1:0]  bru_tkn_pc_i,
  input  logic [XLEN-1:0]  pred_pc_i,
  output logic             flush_o,
  output logic             redir_valid_o,
  output logic [XLEN-1:0]  redir_pc_o,
  input  logic             redir_ready_i,
  output logic             upd_valid_o,
  output logic [XLEN-1:0]  upd_pc_o,
  output logic             upd_tkn_o,
  output logic [XLEN-1:0]  upd_tgt_o,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] mis_cnt_o
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_REDIR = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           r_state;
  state_e           w_state_nxt;

  logic             w_res;
  logic             w_mis;
  logic [XLEN-1:0]  w_act_pc;

  logic             w_flush_d;
  logic             w_redir_valid_d;
  logic             w_redir_load;
  logic             w_upd_valid_d;
  logic [CNT_W-1:0] w_br_cnt_d;
  logic [CNT_W-1:0] w_mis_cnt_d;

  logic             r_flush;
  logic             r_redir_valid;
  logic [XLEN-1:0]  r_redir_pc;
  logic             r_upd_valid;
  upd_t             r_upd;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mis_cnt;

  // Resolve evaluation; only acted on in IDLE since REDIR-cycle ex_* data is wrong-path
  assign w_res    = ex_valid_i && ex_is_ctrl_i;
  assign w_act_pc = bru_tkn_i ? bru_tkn_pc_i : ex_pc_i + XLEN'(4);
  assign w_mis    = w_res && (w_act_pc != pred_pc_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_mis) w_state_nxt = S_REDIR;
      S_REDIR: if (redir_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_flush_d       = 1'b0;
    w_redir_load    = 1'b0;
    w_upd_valid_d   = 1'b0;
    w_br_cnt_d      = r_br_cnt;
    w_mis_cnt_d     = r_mis_cnt;
    w_redir_valid_d = (w_state_nxt == S_REDIR);
    if (r_state == S_IDLE) begin
      w_upd_valid_d = w_res;
      w_flush_d     = w_mis;
      w_redir_load  = w_mis;
      if (w_res && (r_br_cnt != CNT_MAX)) w_br_cnt_d = r_br_cnt + CNT_W'(1);
      if (w_mis && (r_mis_cnt != CNT_MAX)) w_mis_cnt_d = r_mis_cnt + CNT_W'(1);
    end
    if (cnt_clr_i) begin
      w_br_cnt_d  = '0;
      w_mis_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_flush       <= 1'b0;
      r_redir_valid <= 1'b0;
      r_redir_pc    <= '0;
      r_upd_valid   <= 1'b0;
      r_upd         <= '0;
      r_br_cnt      <= '0;
      r_mis_cnt     <= '0;
    end else begin
      r_flush       <= w_flush_d;
      r_redir_valid <= w_redir_valid_d;
      r_upd_valid   <= w_upd_valid_d;
      r_br_cnt      <= w_br_cnt_d;
      r_mis_cnt     <= w_mis_cnt_d;
      if (w_redir_load) r_redir_pc <= w_act_pc;
      if (w_upd_valid_d) begin
        r_upd.pc  <= ex_pc_i;
        r_upd.tkn <= bru_tkn_i;
        r_upd.tgt <= bru_tkn_pc_i;
      end
    end
  end

  assign flush_o       = r_flush;
  assign redir_valid_o = r_redir_valid;
  assign redir_pc_o    = r_redir_pc;
  assign upd_valid_o   = r_upd_valid;
  assign upd_pc_o      = r_upd.pc;
  assign upd_tkn_o     = r_upd.tkn;
  assign upd_tgt_o     = r_upd.tgt;
  assign br_cnt_o      = r_br_cnt;
  assign mis_cnt_o     = r_mis_cnt;

endmodule

// File: tb/tb_bru_redirect_ctrl.sv
// Directed bench for bru_redirect_ctrl with 4-bit counters so saturation is reachable.

module tb_bru_redirect_ctrl;
  localparam int unsigned CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b1;
  logic             ex_valid_i = 1'b0;
  logic             ex_is_ctrl_i = 1'b0;
  logic [31:0]      ex_pc_i = '0;
  logic             bru_tkn_i = 1'b0;
  logic [31:0]      bru_tkn_pc_i = '0;
  logic [31:0]      pred_pc_i = '0;
  logic             flush_o;
  logic             redir_valid_o;
  logic [31:0]      redir_pc_o;
  logic             redir_ready_i = 1'b0;
  logic             upd_valid_o;
  logic [31:0]      upd_pc_o;
  logic             upd_tkn_o;
  logic [31:0]      upd_tgt_o;
  logic             cnt_clr_i = 1'b0;
  logic [CNT_W-1:0] br_cnt_o;
  logic [CNT_W-1:0] mis_cnt_o;

  int n_pass = 0;
  int n_total = 0;

  bru_redirect_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_i), .ex_is_ctrl_i(ex_is_ctrl_i), .ex_pc_i(ex_pc_i),
    .bru_tkn_i(bru_tkn_i), .bru_tkn_pc_i(bru_tkn_pc_i), .pred_pc_i(pred_pc_i),
    .flush_o(flush_o), .redir_valid_o(redir_valid_o), .redir_pc_o(redir_pc_o),
    .redir_ready_i(redir_ready_i),
    .upd_valid_o(upd_valid_o), .upd_pc_o(upd_pc_o), .upd_tkn_o(upd_tkn_o), .upd_tgt_o(upd_tgt_o),
    .cnt_clr_i(cnt_clr_i), .br_cnt_o(br_cnt_o), .mis_cnt_o(mis_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic tkn,
                       input logic [31:0] tgt, input logic [31:0] pred);
    ex_valid_i   = v;
    ex_is_ctrl_i = v;
    ex_pc_i      = pc;
    bru_tkn_i    = tkn;
    bru_tkn_pc_i = tgt;
    pred_pc_i    = pred;
  endtask

  task automatic test_reset();
    #2 rst_ni = 1'b0;
    #1;
    n_total++; if ({flush_o, redir_valid_o, upd_valid_o, upd_tkn_o} !== 4'b0) $display("FAIL por_flags: got %b exp 0000", {flush_o, redir_valid_o, upd_valid_o, upd_tkn_o}); else n_pass++;
    n_total++; if ({redir_pc_o, upd_pc_o, upd_tgt_o, br_cnt_o, mis_cnt_o} !== '0) $display("FAIL por_data: got %h exp 0", {redir_pc_o, upd_pc_o, upd_tgt_o, br_cnt_o, mis_cnt_o}); else n_pass++;
    tick();
    rst_ni = 1'b1;
    // 0xFC not taken resolves to 0x100, prediction 0 -> redirect pending to 0x100
    drive(1'b1, 32'h0000_00FC, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    n_total++; if (redir_valid_o !== 1'b1 || redir_pc_o !== 32'h100) $display("FAIL redir_pending: got v=%b pc=%h exp v=1 pc=00000100", redir_valid_o, redir_pc_o); else n_pass++;
    rst_ni = 1'b0;
    #1;
    n_total++; if ({flush_o, redir_valid_o, upd_valid_o, br_cnt_o, mis_cnt_o} !== '0) $display("FAIL async_rst: got %h exp 0", {flush_o, redir_valid_o, upd_valid_o, br_cnt_o, mis_cnt_o}); else n_pass++;
    n_total++; if (redir_pc_o !== 32'h0) $display("FAIL async_rst_pc: got %h exp 00000000", redir_pc_o); else n_pass++;
    #1 rst_ni = 1'b1;
    tick();
    n_total++; if (redir_valid_o !== 1'b0 || flush_o !== 1'b0) $display("FAIL no_replay: got v=%b f=%b exp 0 0", redir_valid_o, flush_o); else n_pass++;
  endtask

  task automatic test_correct_predict();
    drive(1'b1, 32'h200, 1'b1, 32'h180, 32'h180);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    n_total++; if (upd_valid_o !== 1'b1 || upd_pc_o !== 32'h200 || upd_tkn_o !== 1'b1 || upd_tgt_o !== 32'h180) $display("FAIL hit_upd: got v=%b pc=%h t=%b tgt=%h exp 1 200 1 180", upd_valid_o, upd_pc_o, upd_tkn_o, upd_tgt_o); else n_pass++;
    n_total++; if (br_cnt_o !== 4'd1 || mis_cnt_o !== 4'd0) $display("FAIL hit_cnt: got br=%0d mis=%0d exp 1 0", br_cnt_o, mis_cnt_o); else n_pass++;
    n_total++; if (flush_o !== 1'b0 || redir_valid_o !== 1'b0) $display("FAIL hit_noredir: got f=%b v=%b exp 0 0", flush_o, redir_valid_o); else n_pass++;
    tick();
    n_total++; if (upd_valid_o !== 1'b0) $display("FAIL hit_pulse: got %b exp 0", upd_valid_o); else n_pass++;
  endtask

  task automatic test_mispredict_hold();
    drive(1'b1, 32'h200, 1'b0, 32'h180, 32'h180);
    tick();
    // wrong-path resolves presented while waiting must be ignored
    drive(1'b1, 32'h204, 1'b1, 32'h300, 32'h208);
    n_total++; if (flush_o !== 1'b1 || redir_valid_o !== 1'b1 || redir_pc_o !== 32'h204) $display("FAIL mis_first: got f=%b v=%b pc=%h exp 1 1 204", flush_o, redir_valid_o, redir_pc_o); else n_pass++;
    n_total++; if (upd_valid_o !== 1'b1 || upd_tkn_o !== 1'b0 || upd_pc_o !== 32'h200) $display("FAIL mis_upd: got v=%b t=%b pc=%h exp 1 0 200", upd_valid_o, upd_tkn_o, upd_pc_o); else n_pass++;
    n_total++; if (br_cnt_o !== 4'd2 || mis_cnt_o !== 4'd1) $display("FAIL mis_cnt: got br=%0d mis=%0d exp 2 1", br_cnt_o, mis_cnt_o); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (flush_o !== 1'b0 || redir_valid_o !== 1'b1 || redir_pc_o !== 32'h204) $display("FAIL hold_%0d: got f=%b v=%b pc=%h exp 0 1 204", i, flush_o, redir_valid_o, redir_pc_o); else n_pass++;
      n_total++; if (upd_valid_o !== 1'b0 || br_cnt_o !== 4'd2) $display("FAIL hold_ign_%0d: got upd=%b br=%0d exp 0 2", i, upd_valid_o, br_cnt_o); else n_pass++;
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    redir_ready_i = 1'b1;
    tick();
    redir_ready_i = 1'b0;
    n_total++; if (redir_valid_o !== 1'b0 || flush_o !== 1'b0) $display("FAIL accept: got v=%b f=%b exp 0 0", redir_valid_o, flush_o); else n_pass++;
    n_total++; if (mis_cnt_o !== 4'd1) $display("FAIL accept_cnt: got %0d exp 1", mis_cnt_o); else n_pass++;
  endtask

  task automatic test_single_cycle_redirect();
    redir_ready_i = 1'b1;
    tick();
    n_total++; if (redir_valid_o !== 1'b0) $display("FAIL ready_idle: got %b exp 0", redir_valid_o); else n_pass++;
    drive(1'b1, 32'h300, 1'b1, 32'h400, 32'h304);
    tick();
    // correctly predicted resolve presented in the acceptance cycle
    drive(1'b1, 32'h500, 1'b0, 32'h0, 32'h504);
    n_total++; if (flush_o !== 1'b1 || redir_valid_o !== 1'b1 || redir_pc_o !== 32'h400) $display("FAIL sc_first: got f=%b v=%b pc=%h exp 1 1 400", flush_o, redir_valid_o, redir_pc_o); else n_pass++;
    n_total++; if (br_cnt_o !== 4'd3 || mis_cnt_o !== 4'd2) $display("FAIL sc_cnt: got br=%0d mis=%0d exp 3 2", br_cnt_o, mis_cnt_o); else n_pass++;
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    redir_ready_i = 1'b0;
    n_total++; if (redir_valid_o !== 1'b0 || flush_o !== 1'b0) $display("FAIL sc_done: got v=%b f=%b exp 0 0", redir_valid_o, flush_o); else n_pass++;
    n_total++; if (upd_valid_o !== 1'b0 || br_cnt_o !== 4'd3) $display("FAIL sc_ignored: got upd=%b br=%0d exp 0 3", upd_valid_o, br_cnt_o); else n_pass++;
  endtask

  task automatic test_back_to_back_saturate();
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    n_total++; if (br_cnt_o !== 4'd0 || mis_cnt_o !== 4'd0) $display("FAIL clr: got br=%0d mis=%0d exp 0 0", br_cnt_o, mis_cnt_o); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h1000 + 32'(i * 4), 1'b1, 32'h80, 32'h80);
      tick();
      n_total++; if (upd_valid_o !== 1'b1 || upd_pc_o !== 32'h1000 + 32'(i * 4)) $display("FAIL b2b_upd_%0d: got v=%b pc=%h exp 1 %h", i, upd_valid_o, upd_pc_o, 32'h1000 + 32'(i * 4)); else n_pass++;
      n_total++; if (br_cnt_o !== ((i >= 14) ? 4'd15 : 4'(i + 1))) $display("FAIL sat_%0d: got %0d exp %0d", i, br_cnt_o, (i >= 14) ? 15 : i + 1); else n_pass++;
    end
    drive(1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    n_total++; if (br_cnt_o !== 4'd0 || mis_cnt_o !== 4'd0) $display("FAIL clr_beats_inc: got br=%0d mis=%0d exp 0 0", br_cnt_o, mis_cnt_o); else n_pass++;
    n_total++; if (redir_valid_o !== 1'b1 || redir_pc_o !== 32'h14) $display("FAIL clr_redir: got v=%b pc=%h exp 1 14", redir_valid_o, redir_pc_o); else n_pass++;
    redir_ready_i = 1'b1;
    tick();
    redir_ready_i = 1'b0;
    n_total++; if (redir_valid_o !== 1'b0) $display("FAIL clr_accept: got %b exp 0", redir_valid_o); else n_pass++;
  endtask

  task automatic test_pc_wrap();
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    n_total++; if (upd_valid_o !== 1'b1 || redir_valid_o !== 1'b0 || flush_o !== 1'b0) $display("FAIL wrap_hit: got upd=%b v=%b f=%b exp 1 0 0", upd_valid_o, redir_valid_o, flush_o); else n_pass++;
    n_total++; if (br_cnt_o !== 4'd1 || mis_cnt_o !== 4'd0) $display("FAIL wrap_hit_cnt: got br=%0d mis=%0d exp 1 0", br_cnt_o, mis_cnt_o); else n_pass++;
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h4);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    n_total++; if (redir_valid_o !== 1'b1 || flush_o !== 1'b1 || redir_pc_o !== 32'h0) $display("FAIL wrap_mis: got v=%b f=%b pc=%h exp 1 1 00000000", redir_valid_o, flush_o, redir_pc_o); else n_pass++;
    n_total++; if (br_cnt_o !== 4'd2 || mis_cnt_o !== 4'd1) $display("FAIL wrap_mis_cnt: got br=%0d mis=%0d exp 2 1", br_cnt_o, mis_cnt_o); else n_pass++;
    redir_ready_i = 1'b1;
    tick();
    redir_ready_i = 1'b0;
    n_total++; if (redir_valid_o !== 1'b0) $display("FAIL wrap_accept: got %b exp 0", redir_valid_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_correct_predict();
    test_mispredict_hold();
    test_single_cycle_redirect();
    test_back_to_back_saturate();
    test_pc_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bru_redirect_ctrl.md
# bru_redirect_ctrl

Branch-resolution controller sitting after the BRU in the EX stage. Compares each resolved control-transfer outcome against the fetch-time prediction. On a mispredict it issues a one-cycle younger-instruction flush and a valid/ready redirect to fetch. It also emits a predictor-update pulse for every resolved branch/jump and keeps saturating branch/mispredict counters.

## Interface
Parameters:
- CNT_W, default 32: width of the performance counters.
- XLEN comes from rei_pkg; it is not a module parameter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- ex_valid_i  in  1  EX stage holds a valid instruction
- ex_is_ctrl_i  in  1  that instruction is a branch, jal or jalr
- ex_pc_i  in  XLEN  PC of the EX instruction
- bru_tkn_i  in  1  BRU taken result
- bru_tkn_pc_i  in  XLEN  BRU taken target
- pred_pc_i  in  XLEN  next PC predicted at fetch for this instruction
- flush_o  out  1  kill every instruction younger than the resolving one (IF/ID/EX)
- redir_valid_o  out  1  redirect request to fetch
- redir_pc_o  out  XLEN  redirect target
- redir_ready_i  in  1  fetch accepts the redirect
- upd_valid_o  out  1  predictor update pulse
- upd_pc_o  out  XLEN  PC of the resolved instruction
- upd_tkn_o  out  1  resolved direction
- upd_tgt_o  out  XLEN  resolved taken target
- cnt_clr_i  in  1  synchronous clear of both counters
- br_cnt_o  out  CNT_W  resolved control instructions
- mis_cnt_o  out  CNT_W  mispredicts

## Operation
Resolve event, evaluated only in IDLE:
- res = ex_valid_i && ex_is_ctrl_i
- act_pc = bru_tkn_i ? bru_tkn_pc_i : ex_pc_i + 4, computed modulo 2^XLEN
- mis = res && (act_pc != pred_pc_i), a full XLEN compare

FSM, two states, resets to IDLE:
- IDLE, res && !mis: register the update. Stay in IDLE.
- IDLE, res && mis: register the update, load redir_pc_o = act_pc, go to REDIR.
- REDIR: redir_valid_o = 1 and redir_pc_o held stable. When redir_ready_i = 1, go to IDLE. All ex_* inputs are ignored in REDIR because they are wrong-path.

Outputs, all registered:
- flush_o: 1 for exactly the first cycle of REDIR, then 0.
- upd_*: upd_valid_o pulses for 1 cycle after every res taken in IDLE. upd_pc_o = ex_pc_i, upd_tkn_o = bru_tkn_i, upd_tgt_o = bru_tkn_pc_i.
- Counters: br_cnt_o += 1 on res; mis_cnt_o += 1 on mis. Both saturate at 2^CNT_W - 1 and never wrap.
- cnt_clr_i beats a same-cycle increment: the counter reads 0 on the next cycle.

Reset values: state IDLE; flush_o, redir_valid_o, upd_valid_o, upd_tkn_o = 0; redir_pc_o, upd_pc_o, upd_tgt_o, br_cnt_o, mis_cnt_o = 0.

Boundary cases:
- Reset asserted mid-REDIR: immediately IDLE and redir_valid_o = 0. No redirect is replayed.
- redir_ready_i already high in the first REDIR cycle: accepted that cycle. flush_o and redir_valid_o are both high for that single cycle; IDLE on the next cycle.
- Resolve arriving in the same cycle as acceptance: ignored, because the FSM is still in REDIR.
- redir_ready_i while in IDLE: no effect.
- ex_pc_i = 0xFFFF_FFFC (XLEN=32), not taken: act_pc = 0.
- Not-taken jal/jalr cannot occur, since the BRU always reports taken. No special handling.

## Timing
- Resolve in cycle T gives upd_valid_o and counter updates at T+1.
- Mispredict in T gives flush_o and redir_valid_o at T+1. Earliest return to IDLE is T+2, so earliest next resolve is T+2.
- Redirect handshake: transfer happens in a cycle with valid && ready. valid, once raised, stays high with a stable pc until the transfer.
- Back-to-back correctly predicted resolves: accepted every cycle, one upd pulse per cycle.
- No combinational path from any input to any output.

## Test plan
1. Reset with rst_ni = 0 mid-REDIR (pc 0x100 pending) -> all outputs 0 asynchronously. After release, state IDLE and no redirect.
2. beq at pc 0x200, tkn = 1, tkn_pc = 0x180, pred_pc = 0x180 -> upd_valid_o pulse with tgt 0x180. br_cnt 0→1, mis_cnt stays 0, flush_o and redir_valid_o stay 0.
3. bne at pc 0x200, tkn = 0, pred_pc = 0x180 -> at T+1 flush_o = 1 for one cycle and redir_valid_o = 1 with redir_pc_o = 0x204. Hold redir_ready_i = 0 for 3 cycles: valid and pc stay stable. A ready pulse then returns to IDLE; mis_cnt = 1.
4. jalr mispredict with redir_ready_i = 1 from the first REDIR cycle -> single-cycle redirect. A resolve presented in the acceptance cycle is ignored: no upd pulse, br_cnt unchanged.
5. Force br_cnt to 2^CNT_W - 1 (CNT_W = 4: 15), then one more resolve -> stays 15. Assert cnt_clr_i together with a mispredicting resolve -> both counters read 0 next cycle.
6. pc 0xFFFF_FFFC not taken, pred_pc = 0x0 -> no mispredict. With pred_pc = 0x4 instead -> redirect to 0x0.
